instr_fetch: RTL and testbench



---
 rtl/cpu_pkg.sv | 24 ++
 rtl/instr_fetch_if.sv | 27 ++
 rtl/next_pc_calc.sv | 28 ++
 rtl/instr_fetch.sv | 84 ++++++++
 tb/tb_instr_fetch.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS-style core: opcode constants, fetch FSM
// state encoding, default reset PC and the branch offset helper.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    // Word offset of a branch: sign-extended imm16 scaled to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory handshake toward imem and the
// instruction/PC handoff toward decode and execute.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        instr_accept;
    logic [31:0] pc;
    logic        branch;
    logic        zero;
    logic        jump;
    logic [31:0] retired;

    modport master (
        output imem_req, imem_addr, instr, opcode, instr_valid, pc, retired,
        input  imem_ready, imem_rdata, instr_accept, branch, zero, jump
    );

    modport slave (
        input  imem_req, imem_addr, instr, opcode, instr_valid, pc, retired,
        output imem_ready, imem_rdata, instr_accept, branch, zero, jump
    );
endinterface

// File: rtl/next_pc_calc.sv
// Next-PC selection for the executing instruction: jump beats taken branch,
// which beats sequential pc+4. Unknown control bits fall through to pc+4.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [25:0] instr_i,
    input  logic        branch_i,
    input  logic        zero_i,
    input  logic        jump_i,
    output logic [31:0] next_pc_o
);
    logic [31:0] pc4_s;

    assign pc4_s = pc_i + 32'd4;

    // Priority select; an X control evaluates false and takes the else arm.
    always_comb begin
        next_pc_o = pc4_s;
        if (jump_i) begin
            next_pc_o = {pc4_s[31:28], instr_i, 2'b00};
        end else if (branch_i && zero_i) begin
            next_pc_o = pc4_s + branch_offset(instr_i[15:0]);
        end else begin
            next_pc_o = pc4_s;
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, fetches one word per instruction
// and presents it to decode until the core accepts it.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic            clk,
    input  logic            reset,
    instr_fetch_if.master   fif
);
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic         instr_valid_q;
    logic         imem_req_q;
    logic [31:0]  retired_q;
    logic [31:0]  next_pc_d;

    next_pc_calc u_next_pc (
        .pc_i      (pc_q),
        .instr_i   (instr_q[25:0]),
        .branch_i  (fif.branch),
        .zero_i    (fif.zero),
        .jump_i    (fif.jump),
        .next_pc_o (next_pc_d)
    );

    assign fif.imem_req    = imem_req_q;
    assign fif.imem_addr   = pc_q;
    assign fif.instr       = instr_q;
    assign fif.opcode      = instr_q[31:26];
    assign fif.instr_valid = instr_valid_q;
    assign fif.pc          = pc_q;
    assign fif.retired     = retired_q;

    // Fetch FSM; imem_req/instr_valid are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC_ALIGNED;
            instr_q       <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            retired_q     <= 32'h0000_0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q       <= ST_FETCH;
                    imem_req_q    <= 1'b1;
                    instr_valid_q <= 1'b0;
                end
                ST_FETCH: begin
                    if (fif.imem_ready) begin
                        instr_q       <= fif.imem_rdata;
                        state_q       <= ST_HOLD;
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end else begin
                        state_q       <= ST_FETCH;
                    end
                end
                ST_HOLD: begin
                    if (fif.instr_accept) begin
                        pc_q          <= {next_pc_d[31:2], 2'b00};
                        retired_q     <= retired_q + 32'd1;
                        state_q       <= ST_FETCH;
                        imem_req_q    <= 1'b1;
                        instr_valid_q <= 1'b0;
                    end else begin
                        state_q       <= ST_HOLD;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a table-driven instruction program plus
// hand-written stall, reset-priority and PC-wrap sequences.
module tb_instr_fetch;
    import cpu_pkg::*;

    typedef struct {
        logic [31:0] word;
        logic        br;
        logic        zr;
        logic        jp;
        logic [5:0]  op;
        logic [31:0] next_pc;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[17];

    instr_fetch_if fif ();

    instr_fetch dut (
        .clk   (clk),
        .reset (reset),
        .fif   (fif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"},      fif.pc, 32'h0000_0000);
        check({tag, "_instr"},   fif.instr, 32'h0000_0000);
        check({tag, "_opcode"},  {26'd0, fif.opcode}, 32'd0);
        check({tag, "_valid"},   {31'd0, fif.instr_valid}, 32'd0);
        check({tag, "_req"},     {31'd0, fif.imem_req}, 32'd0);
        check({tag, "_retired"}, fif.retired, 32'd0);
    endtask

    task automatic wait_req();
        int n = 0;
        while (fif.imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("imem_req_seen", {31'd0, fif.imem_req}, 32'd1);
    endtask

    task automatic fetch_word(input logic [31:0] w);
        wait_req();
        fif.imem_ready = 1'b1;
        fif.imem_rdata = w;
        @(negedge clk);
        fif.imem_ready = 1'b0;
        fif.imem_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic accept_instr(input logic b, input logic z, input logic j);
        fif.instr_accept = 1'b1;
        fif.branch = b;
        fif.zero   = z;
        fif.jump   = j;
        @(negedge clk);
        fif.instr_accept = 1'b0;
        fif.branch = 1'b0;
        fif.zero   = 1'b0;
        fif.jump   = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] held;
        int req_cycles;

        vecs[0]  = '{32'h8C01_0004, 1'b0, 1'b0, 1'b0, OP_LW,    32'h0000_0004};
        vecs[1]  = '{32'h0022_1820, 1'b0, 1'b0, 1'b0, OP_RTYPE, 32'h0000_0008};
        vecs[2]  = '{32'hAC01_0000, 1'b0, 1'b0, 1'b0, OP_SW,    32'h0000_000C};
        vecs[3]  = '{32'h0022_1820, 1'b0, 1'b0, 1'b0, OP_RTYPE, 32'h0000_0010};
        vecs[4]  = '{32'h1000_0003, 1'b0, 1'b0, 1'b0, OP_BEQ,   32'h0000_0014};
        vecs[5]  = '{32'h0800_0008, 1'b0, 1'b0, 1'b1, OP_J,     32'h0000_0020};
        vecs[6]  = '{32'h1000_FFFE, 1'b1, 1'b1, 1'b0, OP_BEQ,   32'h0000_001C};
        vecs[7]  = '{32'h0800_0008, 1'b0, 1'b0, 1'b1, OP_J,     32'h0000_0020};
        vecs[8]  = '{32'h1000_FFFE, 1'b1, 1'b0, 1'b0, OP_BEQ,   32'h0000_0024};
        vecs[9]  = '{32'h1000_0010, 1'b0, 1'b1, 1'b0, OP_BEQ,   32'h0000_0028};
        vecs[10] = '{32'h0BFF_FFFF, 1'b0, 1'b0, 1'b1, OP_J,     32'h0FFF_FFFC};
        vecs[11] = '{32'h0BFF_FFFF, 1'b0, 1'b0, 1'b1, OP_J,     32'h1FFF_FFFC};
        vecs[12] = '{32'h0BFF_FFFF, 1'b0, 1'b0, 1'b1, OP_J,     32'h2FFF_FFFC};
        vecs[13] = '{32'h0BFF_FFFF, 1'b0, 1'b0, 1'b1, OP_J,     32'h3FFF_FFFC};
        vecs[14] = '{32'h0800_0002, 1'b0, 1'b0, 1'b1, OP_J,     32'h4000_0008};
        vecs[15] = '{32'h0800_0100, 1'b1, 1'b1, 1'b1, OP_J,     32'h4000_0400};
        vecs[16] = '{32'h1000_0010, 1'b1, 1'b1, 1'b0, OP_BEQ,   32'h4000_0444};

        reset = 1'b1;
        fif.imem_ready = 1'b0;
        fif.imem_rdata = 32'h0000_0000;
        fif.instr_accept = 1'b0;
        fif.branch = 1'b0;
        fif.zero = 1'b0;
        fif.jump = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;
        @(negedge clk);
        check("first_req", {31'd0, fif.imem_req}, 32'd1);
        check("first_req_valid", {31'd0, fif.instr_valid}, 32'd0);

        exp_pc = 32'h0000_0000;
        for (int i = 0; i < 17; i++) begin
            wait_req();
            check("vec_imem_addr", fif.imem_addr, exp_pc);
            fetch_word(vecs[i].word);
            check("vec_instr", fif.instr, vecs[i].word);
            check("vec_opcode", {26'd0, fif.opcode}, {26'd0, vecs[i].op});
            check("vec_hold_excl", {30'd0, fif.instr_valid, fif.imem_req}, 32'd2);
            check("vec_hold_pc", fif.pc, exp_pc);
            accept_instr(vecs[i].br, vecs[i].zr, vecs[i].jp);
            check("vec_next_pc", fif.pc, vecs[i].next_pc);
            check("vec_retired", fif.retired, i + 1);
            check("vec_fetch_excl", {30'd0, fif.instr_valid, fif.imem_req}, 32'd1);
            exp_pc = vecs[i].next_pc;
        end

        // Memory stall of 5 cycles with a stray accept during FETCH.
        req_cycles = 0;
        fif.instr_accept = 1'b1;
        fif.branch = 1'b1;
        fif.zero = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (fif.imem_req === 1'b1) req_cycles++;
            check("stall_valid_low", {31'd0, fif.instr_valid}, 32'd0);
            @(negedge clk);
        end
        if (fif.imem_req === 1'b1) req_cycles++;
        fif.imem_ready = 1'b1;
        fif.imem_rdata = 32'h0022_0820;
        @(negedge clk);
        fif.imem_ready = 1'b0;
        fif.instr_accept = 1'b0;
        fif.branch = 1'b0;
        fif.zero = 1'b0;
        check("stall_req_cycles", req_cycles, 32'd6);
        check("stall_pc_kept", fif.pc, 32'h4000_0444);
        check("stall_retired_kept", fif.retired, 32'd17);
        held = fif.instr;
        check("stall_instr", held, 32'h0022_0820);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_instr_stable", fif.instr, 32'h0022_0820);
            check("hold_valid", {30'd0, fif.instr_valid, fif.imem_req}, 32'd2);
            check("hold_pc_stable", fif.pc, 32'h4000_0444);
        end
        accept_instr(1'b0, 1'b0, 1'b0);
        check("stall_accept_pc", fif.pc, 32'h4000_0448);
        check("stall_accept_retired", fif.retired, 32'd18);

        // Reset in HOLD with accept asserted wins.
        fetch_word(32'h8C01_0004);
        reset = 1'b1;
        fif.instr_accept = 1'b1;
        fif.jump = 1'b1;
        @(negedge clk);
        fif.instr_accept = 1'b0;
        fif.jump = 1'b0;
        check_reset_state("rst_hold");
        reset = 1'b0;

        // Reset in FETCH with ready asserted wins.
        wait_req();
        reset = 1'b1;
        fif.imem_ready = 1'b1;
        fif.imem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        fif.imem_ready = 1'b0;
        check_reset_state("rst_fetch");
        reset = 1'b0;

        // Backward branch from 0 to the top of memory, then sequential wrap.
        fetch_word(32'h1000_FFFE);
        accept_instr(1'b1, 1'b1, 1'b0);
        check("wrap_top_pc", fif.pc, 32'hFFFF_FFFC);
        wait_req();
        check("wrap_top_addr", fif.imem_addr, 32'hFFFF_FFFC);
        fetch_word(32'h0022_1820);
        accept_instr(1'b0, 1'b0, 1'b0);
        check("wrap_zero_pc", fif.pc, 32'h0000_0000);
        check("wrap_retired", fif.retired, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
